// File: rtl/up_timer.sv
// rtl/up_timer.sv - programmable up-counting interval timer with one-shot/auto-reload, pause and clear
module up_timer #(
    parameter int N = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic         stop_i,
    input  logic         clear_i,
    input  logic         reload_i,
    input  logic [N-1:0] limit_i,
    output logic [N-1:0] count_o,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] limit_q, limit_d;
    logic         reload_q, reload_d;
    logic         done_q, done_d;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            count_q  <= '0;
            limit_q  <= '0;
            reload_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            limit_q  <= limit_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        limit_d  = limit_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (clear_i) begin
            // Clear wins over everything, including a completion on this edge.
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_d  = RUN;
                        count_d  = '0;
                        limit_d  = limit_i;
                        reload_d = reload_i;
                    end
                end
                RUN: begin
                    if (count_q == limit_q) begin
                        done_d = 1'b1;
                        if (reload_q) begin
                            count_d = '0;
                            state_d = stop_i ? PAUSED : RUN;
                        end else begin
                            state_d = DONE;
                        end
                    end else if (stop_i) begin
                        state_d = PAUSED;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                PAUSED: begin
                    if (start_i) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign count_o = count_q;
    assign done_o  = done_q;
    assign busy_o  = (state_q == RUN) || (state_q == PAUSED);

endmodule
